addsub_arb: RTL and testbench

ADDSUB_ARB -- requirements
Module: addsub_arb

---
 rtl/addsub_arb_pkg.sv | 32 +++
 rtl/addsub_arb_addsub.sv | 26 ++
 rtl/addsub_arb.sv | 130 +++++++++++++
 tb/tb_addsub_arb.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/addsub_arb_pkg.sv
// Shared types for the two-requester add/subtract arbiter.
// Holds the width default, FSM state type and requester index type.
package addsub_arb_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int N_REQ_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic req_idx_t;

    // Round-robin pick: favoured requester wins a tie, else the lone one.
    function automatic req_idx_t pick_winner(
        input logic [1:0] req,
        input req_idx_t   prio
    );
        req_idx_t w;
        if (req[0] && req[1]) begin
            w = prio;
        end else if (req[1]) begin
            w = 1'b1;
        end else begin
            w = 1'b0;
        end
        return w;
    endfunction

endpackage

// File: rtl/addsub_arb_addsub.sv
// Shared add/subtract datapath: sum = a + b or a - b, modulo 2^WIDTH.
// For subtract, cout = 1 means no borrow occurred.
module addsub_arb_addsub
    import addsub_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] w_b_int;
    logic [WIDTH:0]   w_full;

    // Two's-complement subtract: invert b and inject carry-in.
    always_comb begin
        w_b_int = b ^ {WIDTH{sub}};
        w_full  = {1'b0, a} + {1'b0, w_b_int} + {{WIDTH{1'b0}}, sub};
        sum     = w_full[WIDTH-1:0];
        cout    = w_full[WIDTH];
    end

endmodule

// File: rtl/addsub_arb.sv
// Round-robin arbiter sharing one add/subtract unit between two requesters.
// IDLE grants and latches operands, EXEC computes, RESP holds the result.
module addsub_arb
    import addsub_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sub0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sub1,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] res,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_id,
    output logic             res_valid,
    input  logic             res_ready
);

    state_t           r_state;
    req_idx_t         r_prio;
    req_idx_t         r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;
    req_idx_t         r_id;
    logic             r_valid;

    logic             w_any;
    req_idx_t         w_win;
    logic [N_REQ-1:0] w_gnt;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_bint_msb;
    logic             w_ovf;

    // Single shared datapath, always fed from the operand registers.
    addsub_arb_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (r_a),
        .b    (r_b),
        .sub  (r_sub),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Winner selection and one-hot grant, only while idle and out of reset.
    always_comb begin
        w_any = |req;
        w_win = pick_winner(req[1:0], r_prio);
        w_gnt = '0;
        if ((r_state == ST_IDLE) && w_any && rst_n) begin
            w_gnt[0] = ~w_win;
            w_gnt[1] = w_win;
        end
    end

    // Signed overflow: operands agree in sign but the sum does not.
    always_comb begin
        w_bint_msb = r_b[WIDTH-1] ^ r_sub;
        w_ovf      = (r_a[WIDTH-1] == w_bint_msb) &&
                     (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Control FSM, round-robin pointer, operand and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_id    <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a     <= w_win ? a1 : a0;
                        r_b     <= w_win ? b1 : b0;
                        r_sub   <= w_win ? sub1 : sub0;
                        r_owner <= w_win;
                        r_prio  <= ~w_win;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res   <= w_sum;
                    r_cout  <= w_cout;
                    r_ovf   <= w_ovf;
                    r_id    <= r_owner;
                    r_valid <= 1'b1;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = w_gnt;
    assign res       = r_res;
    assign res_cout  = r_cout;
    assign res_ovf   = r_ovf;
    assign res_id    = r_id;
    assign res_valid = r_valid;

endmodule

// File: tb/tb_addsub_arb.sv
// Directed self-checking bench for addsub_arb.
// Inputs change 1ns after the rising edge; outputs sampled 1-2ns after it.
module tb_addsub_arb;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] a0, b0, a1, b1;
    logic       sub0, sub1;
    logic [1:0] gnt;
    logic [7:0] res;
    logic       res_cout, res_ovf, res_id, res_valid;
    logic       res_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] held;

    addsub_arb #(
        .WIDTH (8),
        .N_REQ (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a0        (a0),
        .b0        (b0),
        .sub0      (sub0),
        .a1        (a1),
        .b1        (b1),
        .sub1      (sub1),
        .gnt       (gnt),
        .res       (res),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: grant, EXEC, result check, accept.
    task automatic txn(input string tag, input logic [1:0] rq,
                       input logic [1:0] rq_after, input logic [1:0] eg,
                       input logic [7:0] er, input logic ec,
                       input logic eo, input logic ei);
        req = rq;
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        tick();
        req = rq_after;
        #1;
        chk({tag, ".exec_gnt"}, 32'(gnt), 32'(2'b00));
        chk({tag, ".exec_valid"}, 32'(res_valid), 32'(1'b0));
        tick();
        chk({tag, ".valid"}, 32'(res_valid), 32'(1'b1));
        chk({tag, ".res"}, 32'(res), 32'(er));
        chk({tag, ".cout"}, 32'(res_cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(res_ovf), 32'(eo));
        chk({tag, ".id"}, 32'(res_id), 32'(ei));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, ".accepted"}, 32'(res_valid), 32'(1'b0));
    endtask

    initial begin
        rst_n = 1'b0;
        req = 2'b00;
        res_ready = 1'b0;
        a0 = 8'h00; b0 = 8'h00; sub0 = 1'b0;
        a1 = 8'h00; b1 = 8'h00; sub1 = 1'b0;
        #1;
        chk("rst.gnt", 32'(gnt), 32'(2'b00));
        chk("rst.res", 32'(res), 32'(8'h00));
        chk("rst.valid", 32'(res_valid), 32'(1'b0));
        chk("rst.id", 32'(res_id), 32'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("idle_ready.valid", 32'(res_valid), 32'(1'b0));

        // 5 + 3
        a0 = 8'h05; b0 = 8'h03; sub0 = 1'b0;
        txn("add0", 2'b01, 2'b00, 2'b01, 8'h08, 1'b0, 1'b0, 1'b0);

        // 3 - 5 borrows
        a1 = 8'h03; b1 = 8'h05; sub1 = 1'b1;
        txn("sub1", 2'b10, 2'b00, 2'b10, 8'hFE, 1'b0, 1'b0, 1'b1);

        // Signed overflow and unsigned wrap
        a0 = 8'h7F; b0 = 8'h01; sub0 = 1'b0;
        txn("ovf", 2'b01, 2'b00, 2'b01, 8'h80, 1'b0, 1'b1, 1'b0);
        a0 = 8'hFF; b0 = 8'h01; sub0 = 1'b0;
        txn("wrap", 2'b01, 2'b00, 2'b01, 8'h00, 1'b1, 1'b0, 1'b0);

        // Round-robin with both requesting, fresh from reset
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        a0 = 8'h10; b0 = 8'h01; sub0 = 1'b0;
        a1 = 8'h20; b1 = 8'h01; sub1 = 1'b1;
        txn("rr1", 2'b11, 2'b11, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0);
        txn("rr2", 2'b11, 2'b11, 2'b10, 8'h1F, 1'b1, 1'b0, 1'b1);
        txn("rr3", 2'b11, 2'b11, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0);
        txn("rr4", 2'b11, 2'b11, 2'b10, 8'h1F, 1'b1, 1'b0, 1'b1);
        req = 2'b00;

        // Backpressure: hold ready low for 5 cycles in RESP
        a0 = 8'h40; b0 = 8'h0A; sub0 = 1'b1;
        req = 2'b01;
        #1;
        chk("bp.gnt", 32'(gnt), 32'(2'b01));
        tick();
        req = 2'b00;
        tick();
        held = 8'h36;
        chk("bp.res0", 32'(res), 32'(held));
        a0 = 8'hAA; b0 = 8'h55;
        req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.valid", 32'(res_valid), 32'(1'b1));
            chk("bp.res", 32'(res), 32'(held));
            chk("bp.gnt", 32'(gnt), 32'(2'b00));
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("bp.acc_valid", 32'(res_valid), 32'(1'b0));
        chk("bp.next_gnt", 32'(gnt), 32'(2'b01));
        a0 = 8'h01; b0 = 8'h02; sub0 = 1'b0;
        tick();
        req = 2'b00;
        tick();
        chk("bp.next_res", 32'(res), 32'(8'h03));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset pulse during EXEC aborts the transaction
        a0 = 8'h09; b0 = 8'h09; sub0 = 1'b0;
        req = 2'b01;
        #1;
        chk("abort.gnt", 32'(gnt), 32'(2'b01));
        tick();
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("abort.res", 32'(res), 32'(8'h00));
        chk("abort.valid", 32'(res_valid), 32'(1'b0));
        chk("abort.gnt0", 32'(gnt), 32'(2'b00));
        chk("abort.cout", 32'(res_cout), 32'(1'b0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort.idle_valid", 32'(res_valid), 32'(1'b0));
            chk("abort.idle_gnt", 32'(gnt), 32'(2'b00));
        end

        // First grant after reset with both requesting goes to 0
        a0 = 8'h02; b0 = 8'h03; sub0 = 1'b1;
        a1 = 8'h05; b1 = 8'h05; sub1 = 1'b0;
        txn("post_rst", 2'b11, 2'b00, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
